// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine for the 5-stage RISC-V pipeline.
// Converts MemRead/MemWrite into a ready/valid transaction on a 64-bit data
// port, lane-aligns stores, sign/zero-extends loads and stalls the pipeline
// until the access retires.
// Optional feature macro: MISALIGN_TRAP_EN (flag misaligned accesses instead of
// silently aligning them down to the access size).
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_MemRead,
  input  logic              i_MemWrite,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_Address,
  input  logic [63:0]       i_StoreData,
  output logic              o_Stall,
  output logic [63:0]       o_MemoryData,
  output logic              o_Done,
`ifdef MISALIGN_TRAP_EN
  output logic              o_Misaligned,
`endif
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [63:0]       dmem_wdata,
  output logic [7:0]        dmem_wstrb,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [63:0]       dmem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          off_q, off_d;
  logic [2:0]          f3_q, f3_d;
  logic                we_q, we_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [7:0]          wstrb_q, wstrb_d;
  logic [63:0]         mdata_q, mdata_d;
`ifdef MISALIGN_TRAP_EN
  logic                mis_q, mis_d;
  logic                misal;
`endif

  logic [2:0]          low_mask;
  logic [7:0]          size_mask;
  logic [2:0]          eff_off;
  logic [63:0]         lanes;
  logic [63:0]         load_ext;

  // Decode access size of the incoming request: alignment mask and byte mask.
  always_comb begin
    low_mask  = 3'b000;
    size_mask = 8'h01;
    case (i_funct3[1:0])
      2'b00: begin low_mask = 3'b000; size_mask = 8'h01; end
      2'b01: begin low_mask = 3'b001; size_mask = 8'h03; end
      2'b10: begin low_mask = 3'b011; size_mask = 8'h0F; end
      default: begin low_mask = 3'b111; size_mask = 8'hFF; end
    endcase
    // Without the trap, size-violating low bits are simply cleared.
    eff_off = i_Address[2:0] & ~low_mask;
`ifdef MISALIGN_TRAP_EN
    misal = |(i_Address[2:0] & low_mask);
`endif
  end

  // Select the addressed lanes of the read data and extend to 64 bits.
  always_comb begin
    lanes    = dmem_rdata >> {off_q, 3'b000};
    load_ext = lanes;
    case (f3_q)
      3'b000: load_ext = {{56{lanes[7]}},  lanes[7:0]};
      3'b001: load_ext = {{48{lanes[15]}}, lanes[15:0]};
      3'b010: load_ext = {{32{lanes[31]}}, lanes[31:0]};
      3'b100: load_ext = {56'd0, lanes[7:0]};
      3'b101: load_ext = {48'd0, lanes[15:0]};
      3'b110: load_ext = {32'd0, lanes[31:0]};
      default: load_ext = lanes;
    endcase
  end

  // Next-state logic: latch the request in IDLE, handshake, capture, retire.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    off_d   = off_q;
    f3_d    = f3_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    mdata_d = mdata_q;
`ifdef MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_MemRead || i_MemWrite) begin
          addr_d  = {i_Address[ADDR_W-1:3], 3'b000};
          off_d   = eff_off;
          f3_d    = i_funct3;
          // A simultaneous read and write is handled as a load.
          we_d    = i_MemWrite & ~i_MemRead;
          wdata_d = i_StoreData << {eff_off, 3'b000};
          wstrb_d = (i_MemWrite & ~i_MemRead) ? (size_mask << eff_off) : 8'h00;
`ifdef MISALIGN_TRAP_EN
          if (misal) begin
            state_d = S_DONE;
            mis_d   = 1'b1;
          end else begin
            state_d = S_REQ;
          end
`else
          state_d = S_REQ;
`endif
        end
      end
      S_REQ: begin
        if (dmem_ready) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          mdata_d = load_ext;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset drops any in-flight access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      mdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      mdata_q <= mdata_d;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // Output drive; stall is gated by reset so all outputs read 0 during reset.
  always_comb begin
    o_Stall      = reset_n & (i_MemRead | i_MemWrite) & (state_q != S_DONE);
    o_Done       = (state_q == S_DONE);
    o_MemoryData = mdata_q;
    dmem_req     = (state_q == S_REQ);
    dmem_we      = (state_q == S_REQ) & we_q;
    dmem_addr    = addr_q;
    dmem_wdata   = wdata_q;
    dmem_wstrb   = wstrb_q;
`ifdef MISALIGN_TRAP_EN
    o_Misaligned = mis_q;
`endif
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios plus randomized accesses
// checked against a byte-addressed memory model.
module tb_mem_access_unit;

  logic        clock;
  logic        reset_n;
  logic        i_MemRead;
  logic        i_MemWrite;
  logic [2:0]  i_funct3;
  logic [31:0] i_Address;
  logic [63:0] i_StoreData;
  logic        o_Stall;
  logic [63:0] o_MemoryData;
  logic        o_Done;
`ifdef MISALIGN_TRAP_EN
  logic        o_Misaligned;
`endif
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:511];
  logic [63:0] last_load;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_MemRead    (i_MemRead),
    .i_MemWrite   (i_MemWrite),
    .i_funct3     (i_funct3),
    .i_Address    (i_Address),
    .i_StoreData  (i_StoreData),
    .o_Stall      (o_Stall),
    .o_MemoryData (o_MemoryData),
    .o_Done       (o_Done),
`ifdef MISALIGN_TRAP_EN
    .o_Misaligned (o_Misaligned),
`endif
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wstrb   (dmem_wstrb),
    .dmem_ready   (dmem_ready),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] mem_dword(input int unsigned a);
    logic [63:0] d;
    int unsigned base;
    base = a & ~32'h7;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = mem[base + i];
    return d;
  endfunction

  // One complete access; expectations come from the byte-level memory model.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [63:0] sdata,
                        input int rlat, input int vlat, input string nm);
    int          sz;
    int unsigned eff, off, exp_addr;
    int          m, stalls, req_seen, since, extra_req, exp_stalls;
    logic [63:0] exp_val, exp_wdata;
    logic [7:0]  exp_wstrb;
    bit          is_load, trap, accepted, done_seen;

    is_load   = rd;
    sz        = 1 << f3[1:0];
    eff       = addr - (addr % sz);
    exp_addr  = eff & ~32'h7;
    off       = eff % 8;
    m         = ((1 << sz) - 1) << off;
    exp_wstrb = m[7:0];
    exp_wdata = sdata << (8 * off);
    exp_val   = '0;
    for (int i = 0; i < sz; i++) exp_val[8*i +: 8] = mem[eff + i];
    for (int j = 8 * sz; j < 64; j++) exp_val[j] = f3[2] ? 1'b0 : exp_val[8*sz-1];
`ifdef MISALIGN_TRAP_EN
    trap = (addr % sz) != 0;
`else
    trap = 1'b0;
`endif
    if (trap) exp_stalls = 1;
    else if (is_load) exp_stalls = 2 + rlat + vlat;
    else exp_stalls = 2 + rlat;

    stalls = 0; req_seen = 0; since = 0; extra_req = 0;
    accepted = 0; done_seen = 0;

    @(negedge clock);
    i_MemRead = rd; i_MemWrite = wr; i_funct3 = f3;
    i_Address = addr; i_StoreData = sdata;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      if (c > 0) @(negedge clock);
      dmem_ready  = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = {$urandom(), $urandom()};
      if (accepted) begin
        since++;
        if (dmem_req) extra_req++;
        if (is_load && since == vlat) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = mem_dword(exp_addr);
        end
      end else if (dmem_req) begin
        if (req_seen == rlat) begin
          dmem_ready  = 1'b1;
          // Junk read data alongside ready must not be captured.
          dmem_rvalid = 1'b1;
          accepted    = 1;
          total++;
          if (dmem_addr !== exp_addr) begin
            bad++; $display("FAIL %s addr: got %h want %h", nm, dmem_addr, exp_addr);
          end
          total++;
          if (dmem_we !== !is_load) begin
            bad++; $display("FAIL %s we: got %b want %b", nm, dmem_we, !is_load);
          end
          if (!is_load) begin
            total++;
            if (dmem_wstrb !== exp_wstrb) begin
              bad++; $display("FAIL %s wstrb: got %h want %h", nm, dmem_wstrb, exp_wstrb);
            end
            total++;
            if (dmem_wdata !== exp_wdata) begin
              bad++; $display("FAIL %s wdata: got %h want %h", nm, dmem_wdata, exp_wdata);
            end
          end
        end
        req_seen++;
      end
      #1;
      if (o_Stall) stalls++;
      if (o_Done) done_seen = 1;
    end

    total++;
    if (!done_seen) begin
      bad++; $display("FAIL %s timeout: done got 0 want 1", nm);
    end
    total++;
    if (stalls != exp_stalls) begin
      bad++; $display("FAIL %s stall_cycles: got %0d want %0d", nm, stalls, exp_stalls);
    end
    total++;
    if (accepted == trap) begin
      bad++; $display("FAIL %s request_issued: got %0d want %0d", nm, accepted, !trap);
    end
    total++;
    if (extra_req != 0) begin
      bad++; $display("FAIL %s duplicate_req: got %0d want 0", nm, extra_req);
    end
    if (is_load && !trap) last_load = exp_val;
    total++;
    if (o_MemoryData !== last_load) begin
      bad++; $display("FAIL %s memdata: got %h want %h", nm, o_MemoryData, last_load);
    end
`ifdef MISALIGN_TRAP_EN
    total++;
    if (o_Misaligned !== trap) begin
      bad++; $display("FAIL %s misaligned: got %b want %b", nm, o_Misaligned, trap);
    end
`endif
    if (!is_load && !trap) begin
      for (int i = 0; i < sz; i++) mem[eff + i] = sdata[8*i +: 8];
    end
    i_MemRead = 1'b0; i_MemWrite = 1'b0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_MemRead = 1'b0; i_MemWrite = 1'b0; i_funct3 = '0;
    i_Address = '0; i_StoreData = '0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    last_load = '0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    repeat (2) @(negedge clock);
    #1;
    total++;
    if ({o_Stall, o_Done, dmem_req, dmem_we} !== 4'b0000) begin
      bad++; $display("FAIL reset ctrl: got %b want 0000", {o_Stall, o_Done, dmem_req, dmem_we});
    end
    total++;
    if ({o_MemoryData, dmem_wdata, dmem_addr, dmem_wstrb} !== '0) begin
      bad++; $display("FAIL reset data: got %h %h %h %h want 0", o_MemoryData, dmem_wdata, dmem_addr, dmem_wstrb);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_store_dword();
    access(1'b0, 1'b1, 3'b011, 32'h100, 64'h1122334455667788, 0, 1, "sd_0x100");
  endtask

  task automatic test_byte();
    access(1'b0, 1'b1, 3'b000, 32'h103, 64'h00000000000000AB, 0, 1, "sb_0x103");
    access(1'b1, 1'b0, 3'b000, 32'h103, 64'h0, 0, 1, "lb_0x103");
    total++;
    if (last_load !== 64'hFFFFFFFFFFFFFFAB) begin
      bad++; $display("FAIL lb_model: got %h want %h", last_load, 64'hFFFFFFFFFFFFFFAB);
    end
    access(1'b1, 1'b0, 3'b100, 32'h103, 64'h0, 1, 2, "lbu_0x103");
  endtask

  task automatic test_latency();
    for (int i = 0; i < 8; i++) mem[32'h100 + i] = 8'h00;
    mem[32'h104] = 8'h01;
    mem[32'h107] = 8'h80;
    access(1'b1, 1'b0, 3'b010, 32'h104, 64'h0, 0, 3, "lw_0x104_slow");
  endtask

  task automatic test_back_to_back();
    access(1'b1, 1'b0, 3'b010, 32'h108, 64'h0, 0, 1, "b2b_lw");
    access(1'b0, 1'b1, 3'b010, 32'h10C, 64'hCAFEF00D12345678, 0, 1, "b2b_sw");
    access(1'b1, 1'b1, 3'b110, 32'h10C, 64'hFFFFFFFFFFFFFFFF, 1, 1, "both_is_load");
  endtask

  task automatic test_misalign();
    mem[32'h100] = 8'h34;
    mem[32'h101] = 8'h82;
    access(1'b1, 1'b0, 3'b001, 32'h101, 64'h0, 0, 1, "lh_0x101");
    access(1'b0, 1'b1, 3'b011, 32'h1A5, 64'h0102030405060708, 0, 1, "sd_0x1a5");
    access(1'b1, 1'b0, 3'b111, 32'h1A0, 64'h0, 0, 1, "ld_0x1a0");
  endtask

  task automatic test_random();
    logic rd, wr;
    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      access(rd, wr, 3'($urandom_range(0, 7)), 32'($urandom_range(0, 32'h1F7)),
             {$urandom(), $urandom()}, int'($urandom_range(0, 3)),
             int'($urandom_range(1, 3)), "random");
    end
  endtask

  task automatic test_reset_mid();
    // Reset while a request is being offered.
    @(negedge clock);
    i_MemRead = 1'b1; i_funct3 = 3'b011; i_Address = 32'h108;
    @(negedge clock);
    #1;
    total++;
    if (dmem_req !== 1'b1) begin
      bad++; $display("FAIL rst_req pre: got %b want 1", dmem_req);
    end
    reset_n = 1'b0; i_MemRead = 1'b0;
    #1;
    total++;
    if ({dmem_req, o_Stall} !== 2'b00) begin
      bad++; $display("FAIL rst_req drop: got %b want 00", {dmem_req, o_Stall});
    end
    @(negedge clock);
    reset_n = 1'b1;
    // Reset while waiting for read data, then a late rvalid.
    @(negedge clock);
    i_MemRead = 1'b1; i_funct3 = 3'b011; i_Address = 32'h108;
    @(negedge clock);
    dmem_ready = 1'b1;
    @(negedge clock);
    dmem_ready = 1'b0;
    #1;
    total++;
    if (o_Stall !== 1'b1) begin
      bad++; $display("FAIL rst_wait pre: stall got %b want 1", o_Stall);
    end
    reset_n = 1'b0; i_MemRead = 1'b0;
    #1;
    total++;
    if ({dmem_req, o_Stall} !== 2'b00) begin
      bad++; $display("FAIL rst_wait drop: got %b want 00", {dmem_req, o_Stall});
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    dmem_rvalid = 1'b1; dmem_rdata = 64'hDEADBEEFDEADBEEF;
    @(negedge clock);
    dmem_rvalid = 1'b0;
    #1;
    total++;
    if ({o_MemoryData, o_Done, dmem_req} !== '0) begin
      bad++; $display("FAIL rst_late_rvalid: got %h %b %b want 0", o_MemoryData, o_Done, dmem_req);
    end
  endtask

  initial begin
    test_reset();
    test_store_dword();
    test_byte();
    test_latency();
    test_back_to_back();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store engine for the 5-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It turns MemRead/MemWrite requests into a ready/valid transaction on a 64-bit data-memory port, with byte-lane alignment on stores and sign/zero extension on loads. It holds the pipeline with o_Stall until the access completes, then presents the load result to MEM/WB.

## Interface
- ADDR_W, 32, byte-address width
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- i_MemRead  in  1  load request (from EX/MEM control)
- i_MemWrite  in  1  store request
- i_funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu, 111 treated as d
- i_Address  in  ADDR_W  byte address (ALU result)
- i_StoreData  in  64  store source (rs2 value)
- o_Stall  out  1  freeze PC/IF/ID/EX/MEM registers
- o_MemoryData  out  64  extended load result, held until next load completes
- o_Done  out  1  one-cycle pulse when an access retires
- o_Misaligned  out  1  misaligned access flag (only present with MISALIGN_TRAP_EN)
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  doubleword-aligned address (bits [2:0] = 0)
- dmem_wdata  out  64  lane-shifted store data
- dmem_wstrb  out  8  byte enables
- dmem_ready  in  1  memory accepts request
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  64  read data

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: if i_MemRead|i_MemWrite, latch address, funct3, direction, wdata, and wstrb, then go to REQ. Otherwise stay.
- Both i_MemRead and i_MemWrite high: treated as a load; the write is ignored.
- REQ: dmem_req=1 with latched fields stable until dmem_ready. On dmem_ready a store goes to DONE and a load goes to WAIT.
- WAIT: on dmem_rvalid, capture the extended data into o_MemoryData and go to DONE. Any rvalid outside WAIT is ignored.
- DONE: o_Done=1, then go to IDLE unconditionally. The next instruction is sampled in the following IDLE cycle.
- o_Stall = (i_MemRead|i_MemWrite) && state != DONE. This is combinational, so the stalled instruction advances exactly at the DONE edge.
- Store lanes: off = addr[2:0]; wdata = i_StoreData << 8*off.
  - wstrb = size mask << off, where size masks are b 0x01, h 0x03, w 0x0F, d 0xFF.
  - funct3 bit 2 is ignored for stores.
- Load: the selected lanes are (rdata >> 8*off) truncated to the size.
  - Sign-extended for b/h/w.
  - Zero-extended for bu/hu/wu.
  - Passed through for d.
- Reset values: all outputs 0, state IDLE. Reset mid-transaction drops dmem_req immediately and discards any in-flight response.

## Timing
- Store: IDLE → REQ → DONE. With ready in the first REQ cycle, o_Stall is high for 2 cycles.
- Load: IDLE → REQ → WAIT → DONE. With ready and rvalid one cycle apart, o_Stall is high for 3 cycles.
- Each extra cycle of ready or rvalid latency adds one stall cycle. There is no timeout.
- dmem_rvalid is never sampled in the cycle ready is accepted; the earliest sample is the next cycle.
- o_MemoryData updates on the DONE-entry edge and is stable while MEM/WB samples it.

## Configuration
- MISALIGN_TRAP_EN defined:
  - An access is misaligned if (h and addr[0]!=0), (w and addr[1:0]!=0), or (d and addr[2:0]!=0).
  - A misaligned access goes IDLE → DONE with no dmem_req and o_Misaligned=1 for that DONE cycle.
  - o_MemoryData is unchanged.
- MISALIGN_TRAP_EN undefined:
  - o_Misaligned does not exist.
  - Size-violating low address bits are forced to 0 (h clears bit0, w clears [1:0], d clears [2:0]) and the access proceeds normally.

## Test plan
- sd 0x1122334455667788 at 0x100, ready immediate → dmem_addr=0x100, wstrb=0xFF, exact wdata; o_Stall 2 cycles; o_Done one pulse.
- sb 0xAB at 0x103 → wstrb=0x08, wdata[31:24]=0xAB. Then lb at 0x103 with rdata 0x00000000AB000000 → o_MemoryData=0xFFFFFFFFFFFFFFAB; lbu → 0x00000000000000AB.
- lw at 0x104, rdata 0x8000000100000000, rvalid 3 cycles after ready → o_MemoryData=0xFFFFFFFF80000001; o_Stall high 5 cycles.
- Back-to-back lw then sw → two separate transactions with exactly one DONE between them; no duplicate request.
- reset_n low while in WAIT → dmem_req=0 and o_Stall deasserts on the input change; a late rvalid leaves o_MemoryData=0.
- lh at 0x101: with MISALIGN_TRAP_EN, o_Misaligned=1 and no dmem_req; without it, dmem_addr=0x100 and the load returns lanes [15:0].
